// File: rtl/fetch_queue_pkg.sv
// Shared types and default constants for the instruction prefetch queue.
// The NOP value matches the bubble that CPU5STAGE injects on a flush.
package fetch_queue_pkg;

  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;
  localparam logic [31:0] DEF_PC_STEP  = 32'd1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side bundle: IM port, IF/ID handshake, redirect request and flush statistic.
interface fetch_queue_if;

  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [31:0] flush_count;

  // Environment side: instruction memory, decode stage and branch unit.
  modport master (
    input  im_addr, out_valid, out_pc, out_inst, flush_count,
    output im_data, stall, redirect, redirect_pc
  );

  modport slave (
    output im_addr, out_valid, out_pc, out_inst, flush_count,
    input  im_data, stall, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_queue_mem.sv
// DEPTH x {pc, inst} register array: one synchronous write port, one combinational read port.
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] wr_addr,
  input  fq_entry_t        wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output fq_entry_t        rd_data
);

  fq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, buffers {pc, inst} pairs from IM
// and presents the oldest one to IF/ID; a redirect flushes and refetches.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_STEP  = DEF_PC_STEP,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [31:0]      fetch_pc;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic [31:0]      flush_count;
  logic             push;
  logic             pop;
  logic             out_valid;
  fq_entry_t        head;

  function automatic logic [31:0] sat_inc(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

  assign out_valid = (count != '0);
  assign pop       = out_valid & ~bus.stall;
  // A full queue can still accept a fetch when the head leaves in the same cycle.
  assign push      = ~bus.redirect & ((count < FULL) | pop);

  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we      (push),
    .wr_addr (wr_ptr),
    .wr_data ('{pc: fetch_pc, inst: bus.im_data}),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      flush_count <= '0;
    end else if (bus.redirect) begin
      // Head is dropped even when decode would have taken it this cycle.
      fetch_pc    <= bus.redirect_pc;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      flush_count <= sat_inc(flush_count);
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + PC_STEP;
        wr_ptr   <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  assign bus.im_addr     = fetch_pc;
  assign bus.out_valid   = out_valid;
  assign bus.out_pc      = out_valid ? head.pc   : 32'd0;
  assign bus.out_inst    = out_valid ? head.inst : NOP_INST;
  assign bus.flush_count = flush_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4) with a combinational IM returning 0x1000_0000+addr.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  fetch_queue_if bus ();

  fetch_queue #(
    .DEPTH    (4),
    .PC_STEP  (32'd1),
    .NOP_INST (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.im_data = 32'h1000_0000 + bus.im_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks        = 0;
    n_err           = 0;
    rst             = 1'b1;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'd0;

    // Reset held for two edges
    step();
    step();
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_pc",    bus.out_pc,      32'd0);
    check("rst_inst",  bus.out_inst,    32'h0000_0000);
    check("rst_addr",  bus.im_addr,     32'd0);
    check("rst_flush", bus.flush_count, 32'd0);

    // Free-running stream after release
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("stream_valid", {31'd0, bus.out_valid}, 32'd1);
      check("stream_pc",    bus.out_pc,   32'(i));
      check("stream_inst",  bus.out_inst, 32'h1000_0000 + 32'(i));
      check("stream_addr",  bus.im_addr,  32'(i + 1));
    end

    // Stall from release: fills to DEPTH and holds
    rst       = 1'b1;
    bus.stall = 1'b1;
    step();
    check("rst2_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst2_addr",  bus.im_addr, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("full_valid", {31'd0, bus.out_valid}, 32'd1);
    check("full_pc",    bus.out_pc,  32'd0);
    check("full_addr",  bus.im_addr, 32'd4);
    step();
    check("full_hold_addr", bus.im_addr, 32'd4);
    check("full_hold_pc",   bus.out_pc,  32'd0);

    // Release stall while full: no bubble
    bus.stall = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("drain_valid", {31'd0, bus.out_valid}, 32'd1);
      check("drain_pc",    bus.out_pc,   32'(k));
      check("drain_inst",  bus.out_inst, 32'h1000_0000 + 32'(k));
      step();
    end

    // Redirect with head at pc 3
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("pre_redir_pc", bus.out_pc, 32'd3);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    step();
    bus.redirect = 1'b0;
    check("redir_valid", {31'd0, bus.out_valid}, 32'd0);
    check("redir_addr",  bus.im_addr,     32'h40);
    check("redir_inst",  bus.out_inst,    32'h0000_0000);
    check("redir_pc0",   bus.out_pc,      32'd0);
    check("redir_flush", bus.flush_count, 32'd1);
    step();
    check("tgt_valid", {31'd0, bus.out_valid}, 32'd1);
    check("tgt_pc",    bus.out_pc,   32'h40);
    check("tgt_inst",  bus.out_inst, 32'h1000_0040);
    check("tgt_addr",  bus.im_addr,  32'h41);

    // Redirect while stalled, then queue three entries
    bus.stall       = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h80;
    step();
    bus.redirect = 1'b0;
    check("redir2_valid", {31'd0, bus.out_valid}, 32'd0);
    check("redir2_flush", bus.flush_count, 32'd2);
    for (int i = 0; i < 3; i++) step();
    check("q3_pc",   bus.out_pc,  32'h80);
    check("q3_addr", bus.im_addr, 32'h83);

    // Reset and redirect together: reset wins
    rst             = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h99;
    step();
    check("rr_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rr_addr",  bus.im_addr,     32'd0);
    check("rr_flush", bus.flush_count, 32'd0);
    check("rr_pc",    bus.out_pc,      32'd0);
    rst          = 1'b0;
    bus.redirect = 1'b0;
    bus.stall    = 1'b0;
    step();
    check("post_rr_valid", {31'd0, bus.out_valid}, 32'd1);
    check("post_rr_pc",    bus.out_pc,  32'd0);
    check("post_rr_addr",  bus.im_addr, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
